// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the 5-stage core.
//   state_t       : pipeline sequencer state (RUN, DWAIT, HALT)
//   hazard_ctrl_t : the PC enable plus the pipeline latch enable and flush bits
//   resolve_run() : priority decode used when the memory stage is not stalling
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic if_dc_en;
    logic if_dc_flush;
    logic dc_ex_en;
    logic dc_ex_flush;
    logic ex_mem_en;
    logic ex_mem_flush;
    logic mem_wb_en;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CtlFreeze = '0;

  // Front-end decode once the memory stage is known to complete this cycle.
  // A redirect wins over load-use and fetch misses: the younger instructions
  // it would stall are being squashed anyway.
  function automatic hazard_ctrl_t resolve_run(input logic redirect,
                                               input logic lu,
                                               input logic ihit);
    hazard_ctrl_t c;
    c = '{pc_en: 1'b1, if_dc_en: 1'b1, if_dc_flush: 1'b0, dc_ex_en: 1'b1,
          dc_ex_flush: 1'b0, ex_mem_en: 1'b1, ex_mem_flush: 1'b0, mem_wb_en: 1'b1};
    if (redirect) begin
      c.if_dc_flush = 1'b1;
      c.dc_ex_flush = 1'b1;
    end else if (lu) begin
      // Hold PC and fetch/decode, send a bubble into execute.
      c.pc_en       = 1'b0;
      c.if_dc_en    = 1'b0;
      c.dc_ex_flush = 1'b1;
    end else if (!ihit) begin
      // No instruction arrived: hold PC, drain a NOP into decode.
      c.pc_en       = 1'b0;
      c.if_dc_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator (purely combinational).
//   memtoreg : execute-stage instruction is a load
//   wsel     : execute-stage destination register
//   rs, rt   : decode-stage source registers
//   lu       : decode instruction needs the load result not yet available
module hazard_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             memtoreg,
  input  logic [REG_W-1:0] wsel,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output logic             lu
);

  // Register 0 is hardwired to zero, so a load into it never creates a hazard.
  assign lu = memtoreg && (wsel != '0) && ((wsel == rs) || (wsel == rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage core.
//   CLK, nRST          : clock, asynchronous active-low reset
//   ihit, dhit         : instruction / data memory ready this cycle
//   mem_dren/dwen/halt : memory-stage load, store, halt
//   ex_memtoreg/wsel   : execute-stage load and its destination
//   dc_rs, dc_rt       : decode-stage sources
//   ex_redirect        : taken branch / jump resolved in execute
//   pc_en, *_en, *_flush : PC and pipeline latch controls (combinational)
//   halt               : sticky halted flag
//   stall_cnt          : saturating count of non-halted cycles with pc_en=0
//   flush_cnt          : saturating count of accepted redirects
module pipe_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_halt,
  input  logic             ex_memtoreg,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] dc_rs,
  input  logic [REG_W-1:0] dc_rt,
  input  logic             ex_redirect,
  output logic             pc_en,
  output logic             if_dc_en,
  output logic             if_dc_flush,
  output logic             dc_ex_en,
  output logic             dc_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t       state_q, state_d;
  hazard_ctrl_t ctl;
  logic         lu, dreq, redirect_acc;
  logic         halt_q, halt_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .memtoreg (ex_memtoreg),
    .wsel     (ex_wsel),
    .rs       (dc_rs),
    .rt       (dc_rt),
    .lu       (lu)
  );

  assign dreq = mem_dren | mem_dwen;

  always_comb begin
    state_d      = state_q;
    ctl          = CtlFreeze;
    redirect_acc = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_halt) begin
          state_d = HALT;
        end else if (dreq && !dhit) begin
          state_d = DWAIT;
        end else begin
          ctl          = resolve_run(ex_redirect, lu, ihit);
          redirect_acc = ex_redirect;
        end
      end
      DWAIT: begin
        if (dhit) begin
          state_d      = RUN;
          ctl          = resolve_run(ex_redirect, lu, ihit);
          redirect_acc = ex_redirect;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = RUN;
    endcase
    // Latches must stay quiet while the core is held in reset.
    if (!nRST) begin
      ctl          = CtlFreeze;
      redirect_acc = 1'b0;
    end
  end

  assign halt_d = halt_q | (state_q == RUN && mem_halt);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      if (!ctl.pc_en && state_q != HALT && stall_q != '1) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (redirect_acc && flush_q != '1) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign pc_en        = ctl.pc_en;
  assign if_dc_en     = ctl.if_dc_en;
  assign if_dc_flush  = ctl.if_dc_flush;
  assign dc_ex_en     = ctl.dc_ex_en;
  assign dc_ex_flush  = ctl.dc_ex_flush;
  assign ex_mem_en    = ctl.ex_mem_en;
  assign ex_mem_flush = ctl.ex_mem_flush;
  assign mem_wb_en    = ctl.mem_wb_en;
  assign halt         = halt_q;
  assign stall_cnt    = stall_q;
  assign flush_cnt    = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  // Control vector order: pc, ifdc_en, ifdc_fl, dcex_en, dcex_fl, exmem_en, exmem_fl, memwb
  localparam logic [7:0] CRun   = 8'b1101_0101;
  localparam logic [7:0] CZero  = 8'b0000_0000;
  localparam logic [7:0] CRedir = 8'b1111_1101;
  localparam logic [7:0] CLu    = 8'b0001_1101;
  localparam logic [7:0] CImiss = 8'b0111_0101;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, mem_dren, mem_dwen, mem_halt, ex_memtoreg, ex_redirect;
  logic [REG_W-1:0] ex_wsel, dc_rs, dc_rt;
  logic             pc_en, if_dc_en, if_dc_flush, dc_ex_en, dc_ex_flush;
  logic             ex_mem_en, ex_mem_flush, mem_wb_en, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0]       ctl;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(
    .REG_W (REG_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .dhit         (dhit),
    .mem_dren     (mem_dren),
    .mem_dwen     (mem_dwen),
    .mem_halt     (mem_halt),
    .ex_memtoreg  (ex_memtoreg),
    .ex_wsel      (ex_wsel),
    .dc_rs        (dc_rs),
    .dc_rt        (dc_rt),
    .ex_redirect  (ex_redirect),
    .pc_en        (pc_en),
    .if_dc_en     (if_dc_en),
    .if_dc_flush  (if_dc_flush),
    .dc_ex_en     (dc_ex_en),
    .dc_ex_flush  (dc_ex_flush),
    .ex_mem_en    (ex_mem_en),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_en    (mem_wb_en),
    .halt         (halt),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  assign ctl = {pc_en, if_dc_en, if_dc_flush, dc_ex_en, dc_ex_flush,
                ex_mem_en, ex_mem_flush, mem_wb_en};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    chk({tag, " flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
  endtask

  // Advance one clock, then let registered outputs settle.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0; mem_halt = 1'b0;
    ex_memtoreg = 1'b0; ex_redirect = 1'b0; ex_wsel = '0; dc_rs = '0; dc_rt = '0;
  endtask

  initial begin
    idle_inputs();
    nRST = 1'b0;

    // Reset: everything quiet even with ihit high.
    step(); step();
    chk("reset ctl", 32'(ctl), 32'(CZero));
    chk("reset halt", 32'(halt), 32'd0);
    chk("reset state", 32'(dut.state_q), 32'(RUN));
    chk_cnt("reset");
    nRST = 1'b1;

    // Free-running with no hazards.
    for (int i = 0; i < 10; i++) begin
      #1 chk("run ctl", 32'(ctl), 32'(CRun));
      step();
    end
    chk_cnt("run");

    // Load-use on rt.
    ex_memtoreg = 1'b1; ex_wsel = 5'd5; dc_rt = 5'd5;
    #1 chk("lu rt ctl", 32'(ctl), 32'(CLu));
    step(); exp_stall++;
    // Load into r0 is not a hazard.
    ex_wsel = 5'd0; dc_rt = 5'd0;
    #1 chk("lu r0 ctl", 32'(ctl), 32'(CRun));
    step();
    chk_cnt("lu rt");
    // Load-use on rs.
    ex_wsel = 5'd7; dc_rs = 5'd7; dc_rt = 5'd3;
    #1 chk("lu rs ctl", 32'(ctl), 32'(CLu));
    step(); exp_stall++;
    // Load with non-matching sources.
    dc_rs = 5'd6;
    #1 chk("lu nomatch ctl", 32'(ctl), 32'(CRun));
    step();
    idle_inputs();
    chk_cnt("lu rs");

    // Instruction miss.
    ihit = 1'b0;
    #1 chk("imiss ctl", 32'(ctl), 32'(CImiss));
    step(); exp_stall++;
    ihit = 1'b1;
    chk_cnt("imiss");

    // Data wait for 3 cycles, completes on the 4th.
    mem_dren = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("dwait ctl", 32'(ctl), 32'(CZero));
      step(); exp_stall++;
      chk("dwait state", 32'(dut.state_q), 32'(DWAIT));
    end
    dhit = 1'b1;
    #1 chk("dwait exit ctl", 32'(ctl), 32'(CRun));
    step();
    chk("dwait exit state", 32'(dut.state_q), 32'(RUN));
    idle_inputs();
    chk_cnt("dwait");

    // Redirect overrides load-use and instruction miss.
    ex_redirect = 1'b1; ex_memtoreg = 1'b1; ex_wsel = 5'd5; dc_rs = 5'd5; ihit = 1'b0;
    #1 chk("redirect ctl", 32'(ctl), 32'(CRedir));
    step(); exp_flush++;
    idle_inputs();
    chk_cnt("redirect");

    // Redirect accepted on DWAIT exit.
    mem_dwen = 1'b1;
    #1 step(); exp_stall++;
    dhit = 1'b1; ex_redirect = 1'b1;
    #1 chk("dwait redirect ctl", 32'(ctl), 32'(CRedir));
    step(); exp_flush++;
    idle_inputs();
    chk_cnt("dwait redirect");

    // Halt: frozen and sticky regardless of other inputs.
    mem_halt = 1'b1;
    #1 chk("halt entry ctl", 32'(ctl), 32'(CZero));
    step(); exp_stall++;
    mem_halt = 1'b0; ihit = 1'b1; dhit = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("halted ctl", 32'(ctl), 32'(CZero));
      chk("halted flag", 32'(halt), 32'd1);
      step();
    end
    chk_cnt("halted");
    nRST = 1'b0; exp_stall = 0; exp_flush = 0;
    #1 chk("halt reset flag", 32'(halt), 32'd0);
    chk("halt reset ctl", 32'(ctl), 32'(CZero));
    chk_cnt("halt reset");
    idle_inputs();
    step();
    nRST = 1'b1;
    #1 chk("post halt run ctl", 32'(ctl), 32'(CRun));

    // Reset in the middle of a data wait.
    mem_dren = 1'b1; dhit = 1'b0;
    step(); step(); exp_stall = 2;
    chk("pre reset state", 32'(dut.state_q), 32'(DWAIT));
    chk_cnt("pre reset");
    nRST = 1'b0; exp_stall = 0;
    #1 chk("mid dwait reset state", 32'(dut.state_q), 32'(RUN));
    chk_cnt("mid dwait reset");
    mem_dren = 1'b0;
    step();
    nRST = 1'b1;
    dhit = 1'b1;
    #1 chk("stray dhit ctl", 32'(ctl), 32'(CRun));
    step();
    chk_cnt("stray dhit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
